// File: rtl/alu_multiword_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer: processor flag slots,
// the single-word ALU opcode set, and the sequencer state/op helpers.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

package pkg_pflags;
  localparam int pf_width  = `PROC_FLAGS_MSB_POS + 1;
  localparam int pf_slot_c = 0;
  localparam int pf_slot_z = 1;
  localparam int pf_slot_n = 2;
  localparam int pf_slot_v = 3;
endpackage

package pkg_alu;
  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_adc  = 4'd1,
    alu_sub  = 4'd2,
    alu_sbc  = 4'd3,
    alu_cmp  = 4'd4,
    alu_and  = 4'd5,
    alu_orr  = 4'd6,
    alu_xor  = 4'd7,
    alu_lsl  = 4'd8,
    alu_lsr  = 4'd9,
    alu_asr  = 4'd10,
    alu_rol  = 4'd11,
    alu_ror  = 4'd12,
    alu_rolc = 4'd13,
    alu_rorc = 4'd14
  } alu_op_t;
endpackage

package pkg_alu_seq;
  import pkg_alu::*;

  typedef enum logic [1:0] {
    seq_idle,
    seq_exec,
    seq_done
  } seq_state_t;

  // Upper words continue the carry chain: additions become adc and all
  // subtraction-like ops become sbc; logic ops are word-independent.
  function automatic alu_op_t map_op(input alu_op_t op, input logic first_word);
    alu_op_t mapped;
    mapped = op;
    if (!first_word) begin
      case (op)
        alu_add, alu_adc:          mapped = alu_adc;
        alu_sub, alu_sbc, alu_cmp: mapped = alu_sbc;
        default:                   mapped = op;
      endcase
    end
    return mapped;
  endfunction

  function automatic logic is_supported(input alu_op_t op);
    case (op)
      alu_add, alu_adc, alu_sub, alu_sbc, alu_cmp,
      alu_and, alu_orr, alu_xor: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_multiword_seq_alu.sv
// Existing single-word combinational ALU. Carry convention: sub/cmp give
// C=1 for no borrow, sbc consumes C as not-borrow; logic ops leave C alone.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

module alu
  import pkg_alu::*;
  import pkg_pflags::*;
(
  input  alu_op_t                            op,
  input  logic [`ALU_INOUT_WIDTH-1:0]        a,
  input  logic [`ALU_INOUT_WIDTH-1:0]        b,
  input  logic [`PROC_FLAGS_MSB_POS:0]       flags_in,
  output logic [`ALU_INOUT_WIDTH-1:0]        result,
  output logic [`PROC_FLAGS_MSB_POS:0]       flags_out
);
  localparam int W = `ALU_INOUT_WIDTH;

  logic [W:0] sum;
  logic       cin;
  logic       c_out;
  logic       v_out;
  logic       arith;

  // Single-word operation and flag generation.
  always_comb begin
    cin    = flags_in[pf_slot_c];
    sum    = '0;
    result = a;
    c_out  = cin;
    v_out  = flags_in[pf_slot_v];
    arith  = 1'b0;
    case (op)
      alu_add:          begin sum = {1'b0, a} + {1'b0, b};                     arith = 1'b1; end
      alu_adc:          begin sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);       arith = 1'b1; end
      alu_sub, alu_cmp: begin sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);        arith = 1'b1; end
      alu_sbc:          begin sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);      arith = 1'b1; end
      alu_and:  result = a & b;
      alu_orr:  result = a | b;
      alu_xor:  result = a ^ b;
      alu_lsl:  begin result = {a[W-2:0], 1'b0};   c_out = a[W-1]; end
      alu_lsr:  begin result = {1'b0, a[W-1:1]};   c_out = a[0];   end
      alu_asr:  begin result = {a[W-1], a[W-1:1]}; c_out = a[0];   end
      alu_rol:  begin result = {a[W-2:0], a[W-1]}; c_out = a[W-1]; end
      alu_ror:  begin result = {a[0], a[W-1:1]};   c_out = a[0];   end
      alu_rolc: begin result = {a[W-2:0], cin};    c_out = a[W-1]; end
      alu_rorc: begin result = {cin, a[W-1:1]};    c_out = a[0];   end
      default:  result = a;
    endcase
    if (arith) begin
      result = sum[W-1:0];
      c_out  = sum[W];
      if (op == alu_add || op == alu_adc)
        v_out = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      else
        v_out = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
    end
    flags_out            = flags_in;
    flags_out[pf_slot_c] = c_out;
    flags_out[pf_slot_z] = (result == '0);
    flags_out[pf_slot_n] = result[W-1];
    flags_out[pf_slot_v] = v_out;
  end
endmodule

// File: rtl/alu_multiword_seq.sv
// Multi-precision sequencer: walks NUM_WORDS word pairs LSW-first through
// one ALU instance, chaining carry and accumulating the zero flag.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

module alu_multiword_seq
  import pkg_alu::*;
  import pkg_pflags::*;
  import pkg_alu_seq::*;
#(
  parameter int NUM_WORDS = 2,
  parameter int WORD_W    = `ALU_INOUT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  alu_op_t                       req_op,
  input  logic [NUM_WORDS*WORD_W-1:0]   req_a,
  input  logic [NUM_WORDS*WORD_W-1:0]   req_b,
  input  logic [`PROC_FLAGS_MSB_POS:0]  req_flags,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_WORDS*WORD_W-1:0]   rsp_result,
  output logic [`PROC_FLAGS_MSB_POS:0]  rsp_flags,
  output logic                          rsp_err
);
  localparam int FW    = `PROC_FLAGS_MSB_POS + 1;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [FW-1:0]    CZ_MASK   = FW'((1 << pf_slot_c) | (1 << pf_slot_z));

  seq_state_t state, state_nxt;

  logic [CNT_W-1:0]            cnt;
  logic [NUM_WORDS*WORD_W-1:0] a_reg;
  logic [NUM_WORDS*WORD_W-1:0] b_reg;
  alu_op_t                     op_reg;
  logic [FW-1:0]               flags_reg;
  logic                        carry;
  logic                        zacc;

  alu_op_t                     alu_op;
  logic [WORD_W-1:0]           alu_a;
  logic [WORD_W-1:0]           alu_b;
  logic [FW-1:0]               alu_flags_in;
  logic [WORD_W-1:0]           alu_result;
  logic [FW-1:0]               alu_flags_out;
  logic [FW-1:0]               final_flags;

  alu u_alu (
    .op        (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .flags_in  (alu_flags_in),
    .result    (alu_result),
    .flags_out (alu_flags_out)
  );

  // Current word selection and ALU control; final flags take C/Z from the
  // chain and every other bit from the latched request flags.
  always_comb begin
    alu_op                  = map_op(op_reg, cnt == '0);
    alu_a                   = a_reg[int'(cnt)*WORD_W +: WORD_W];
    alu_b                   = b_reg[int'(cnt)*WORD_W +: WORD_W];
    alu_flags_in            = flags_reg;
    alu_flags_in[pf_slot_c] = carry;
    final_flags             = (alu_flags_out & CZ_MASK) | (flags_reg & ~CZ_MASK);
    final_flags[pf_slot_z]  = zacc & alu_flags_out[pf_slot_z];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= seq_idle;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      seq_idle: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = is_supported(req_op) ? seq_exec : seq_done;
      end
      seq_exec: if (cnt == LAST_WORD) state_nxt = seq_done;
      seq_done: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = seq_idle;
      end
      default:  state_nxt = seq_idle;
    endcase
  end

  // Operand latching, per-word result/carry/zero updates and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= alu_add;
      flags_reg  <= '0;
      carry      <= 1'b0;
      zacc       <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        seq_idle: if (req_valid) begin
          // Result starts as A so cmp, which never writes, returns A.
          rsp_result <= req_a;
          if (is_supported(req_op)) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            op_reg    <= req_op;
            flags_reg <= req_flags;
            carry     <= req_flags[pf_slot_c];
            zacc      <= 1'b1;
            cnt       <= '0;
          end else begin
            rsp_flags <= req_flags;
            rsp_err   <= 1'b1;
          end
        end
        seq_exec: begin
          if (op_reg != alu_cmp) rsp_result[int'(cnt)*WORD_W +: WORD_W] <= alu_result;
          carry <= alu_flags_out[pf_slot_c];
          zacc  <= zacc & alu_flags_out[pf_slot_z];
          if (cnt == LAST_WORD) begin
            cnt       <= '0;
            rsp_flags <= final_flags;
            rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed scoreboard bench for alu_multiword_seq with NUM_WORDS=2, 8-bit words.
// Flag slots: bit0=C, bit1=Z, bit2=N, bit3=V.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 3
`endif

module tb_alu_multiword_seq;
  import pkg_alu::*;

  localparam int NW = 2;
  localparam int DW = NW * `ALU_INOUT_WIDTH;
  localparam int FW = `PROC_FLAGS_MSB_POS + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic [FW-1:0] flg;
    logic          err;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  alu_op_t       req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [FW-1:0] req_flags;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [FW-1:0] rsp_flags;
  logic          rsp_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_multiword_seq #(.NUM_WORDS(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_flags  (req_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one request, wait (bounded) for the response, compare against the
  // scoreboard entry. Latency counts edges starting with the accept edge.
  task automatic run_req(input string tag, input alu_op_t op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [FW-1:0] f, input logic [DW-1:0] er,
                         input logic [FW-1:0] ef, input logic ee, input int el);
    exp_t e;
    int   n;
    e.res = er; e.flg = ef; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_flags = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, 32'(n), 32'(e.lat));
    check({tag, ".result"},  32'(rsp_result), 32'(e.res));
    check({tag, ".flags"},   32'(rsp_flags), 32'(e.flg));
    check({tag, ".err"},     32'(rsp_err), 32'(e.err));
    check({tag, ".busy"},    32'(req_ready), 32'd0);
  endtask

  task automatic handshake(input string tag, input logic [DW-1:0] held);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".drop"},  32'(rsp_valid), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".held"},  32'(rsp_result), 32'(held));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = alu_add;
    req_a = '0; req_b = '0; req_flags = '0; rsp_ready = 1'b0;
    #1;
    check("rst.valid",  32'(rsp_valid), 32'd0);
    check("rst.result", 32'(rsp_result), 32'd0);
    check("rst.flags",  32'(rsp_flags), 32'd0);
    check("rst.err",    32'(rsp_err), 32'd0);
    check("rst.ready",  32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req("add_carry", alu_add, 16'h00FF, 16'h0001, 4'h0, 16'h0100, 4'h0, 1'b0, 3);
    handshake("add_carry", 16'h0100);
    run_req("add_wrap",  alu_add, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'h3, 1'b0, 3);
    handshake("add_wrap", 16'h0000);
    run_req("adc",       alu_adc, 16'h00FF, 16'h0000, 4'h1, 16'h0100, 4'h0, 1'b0, 3);
    handshake("adc", 16'h0100);
    run_req("sub",       alu_sub, 16'h0100, 16'h0001, 4'h0, 16'h00FF, 4'h1, 1'b0, 3);
    handshake("sub", 16'h00FF);
    run_req("sbc",       alu_sbc, 16'h0005, 16'h0005, 4'h0, 16'hFFFF, 4'h0, 1'b0, 3);
    handshake("sbc", 16'hFFFF);
    run_req("cmp",       alu_cmp, 16'h1234, 16'h1234, 4'h0, 16'h1234, 4'h3, 1'b0, 3);
    handshake("cmp", 16'h1234);
    run_req("xor",       alu_xor, 16'hA5A5, 16'hA5A5, 4'hD, 16'h0000, 4'hF, 1'b0, 3);
    handshake("xor", 16'h0000);
    run_req("and",       alu_and, 16'hF0F0, 16'hFF00, 4'h0, 16'hF000, 4'h0, 1'b0, 3);
    handshake("and", 16'hF000);
    run_req("orr_zero",  alu_orr, 16'h0000, 16'h0000, 4'h0, 16'h0000, 4'h2, 1'b0, 3);
    handshake("orr_zero", 16'h0000);
    run_req("lsl_err",   alu_lsl, 16'hBEEF, 16'h1111, 4'h5, 16'hBEEF, 4'h5, 1'b1, 1);
    handshake("lsl_err", 16'hBEEF);
    run_req("bad_op",    alu_op_t'(4'hF), 16'h1357, 16'h0000, 4'hA, 16'h1357, 4'hA, 1'b1, 1);
    handshake("bad_op", 16'h1357);

    // Back-pressure: response must hold while a stray request is presented.
    run_req("bp", alu_add, 16'h0003, 16'h0004, 4'h0, 16'h0007, 4'h0, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = alu_sub; req_a = 16'hFFFF; req_b = 16'h0001;
      @(posedge clk); #1;
      check("bp.valid",  32'(rsp_valid), 32'd1);
      check("bp.result", 32'(rsp_result), 32'h0007);
      check("bp.flags",  32'(rsp_flags), 32'h0);
      check("bp.ready",  32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    handshake("bp", 16'h0007);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    req_valid = 1'b1; req_op = alu_add; req_a = 16'h1111; req_b = 16'h2222; req_flags = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.valid",  32'(rsp_valid), 32'd0);
    check("midrst.result", 32'(rsp_result), 32'd0);
    check("midrst.flags",  32'(rsp_flags), 32'd0);
    check("midrst.err",    32'(rsp_err), 32'd0);
    check("midrst.ready",  32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("post_rst", alu_add, 16'h0001, 16'h0001, 4'h0, 16'h0002, 4'h0, 1'b0, 3);
    handshake("post_rst", 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
